mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single-port 256×8 synchronous-read memory between the UART memory controller (requester 0) and a second on-chip client (requester 1).
- Round-robin arbitration decides which requester owns the memory each cycle.
- A requester may lock the memory for multi-cycle sequences such as read-modify-write; a timeout limits how long a lock is held.
- Read data is returned to the requester that issued the read, with a valid strobe.
- The memory instance sits outside this block; the arbiter drives its port and receives its `dout`.

## Interface
Parameters:
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 8, memory word width.
- MAX_LOCK, 16, maximum number of cycles a lock may be held; must be ≥ 2.

Ports (`i` ∈ {0,1}):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_i  in  1  access request, held until acked.
- lock_i  in  1  keep ownership after this access.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  access address.
- wdata_i  in  DATA_WIDTH  write data.
- ack_i  out  1  access performed this cycle (combinational).
- rvalid_i  out  1  read data valid (registered).
- rdata_i  out  DATA_WIDTH  read data; meaningful only while rvalid_i is high.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data; valid one cycle after the address is presented.
- state_out  out  2  current FSM state, intended for LEDs.

## Operation
FSM states: IDLE=0, OWN0=1, OWN1=2.

- **IDLE:**
  - If exactly one req_i is high, that requester wins.
  - If both are high, the requester other than `last` wins.
  - The winner gets ack_i=1.
  - If the winner's lock_i is high, go to OWN_i and clear the lock counter.
- **OWN_i:**
  - Only requester i can be acked; the other requester's req is held off with no ack.
  - The lock counter increments every cycle spent in OWN_i.
  - If lock_i=0 this cycle, go to IDLE. A concurrent req_i is still acked; this is the final access of the locked sequence.
  - If the counter reaches MAX_LOCK−1, go to IDLE regardless of lock_i.
- **Pointer:** `last` is set to i on every ack_i.
- **Memory port:**
  - Driven from the acked requester: mem_we = we_i, mem_addr = addr_i, mem_din = wdata_i.
  - With no ack: mem_we=0, mem_addr=0, mem_din=0.
- **Read return:**
  - A read ack (we_i=0) sets rvalid_i=1 for exactly the next cycle.
  - rdata_i = mem_dout during that cycle, and 0 otherwise.
- **Acks:** ack0 and ack1 are never high in the same cycle.
- **Locks:** lock_i is ignored unless it accompanies an ack (in IDLE) or requester i is already the owner.

## Timing
- **Reset values:** state=IDLE, `last`=1 (so requester 0 wins the first tie), lock counter=0, rvalid_i=0, rdata_i=0, ack_i=0, mem_we=0, state_out=0.
- **Reset mid-operation:** a pending rvalid is dropped and any lock is released; the next cycle arbitrates from reset state.
- **Latencies:**
  - Request to ack: 0 cycles when uncontested.
  - Ack to rvalid: 1 cycle.
  - Write takes effect at the ack edge.
- **Throughput:** back-to-back acks are allowed, one access per cycle total.
- **Fairness:** under continuous contention with no locks, acks alternate 0,1,0,1.
- **Timeout:** after a timeout from OWN_i, a contending requester j wins the next IDLE cycle, because `last`=i.
- **Same-cycle priority:** lock release (lock_i=0) and timeout in the same cycle resolve identically, to IDLE.

## Structure
- **Shared package `mem_arb_pkg`:**
  - State encodings IDLE/OWN0/OWN1.
  - Default ADDR_WIDTH/DATA_WIDTH.
  - Lock-counter width `$clog2(MAX_LOCK)`.
- **Sub-module `mem_arb_rr_pick`:** a combinational 2-way round-robin picker (inputs req[1:0] and last; outputs a one-hot grant), instantiated once by mem_arbiter.
- **mem_arbiter:** holds the FSM, lock counter, `last` pointer, rvalid/rdata registers and port muxing.

## Test plan
- **Single read:** after reset, write 0xA5 to address 0x10 via requester 0, then read 0x10 via requester 0.
  - ack0 in the request cycle.
  - rvalid0=1 with rdata0=0xA5 the next cycle.
  - rvalid1 stays 0.
- **Contention:** req0 and req1 held high for 6 cycles, no locks.
  - Acks go 0,1,0,1,0,1.
  - ack0&ack1 is never high.
- **Locked read-modify-write:** requester 1 reads 0x20 with lock1=1 while req0 is held high.
  - Requester 1 writes 0x20 with lock1=0.
  - ack0 is suppressed until the cycle after that write.
  - Read of 0x20 returns the new value.
- **Lock timeout:** with MAX_LOCK=4, requester 0 holds lock0=1 and req0=1 continuously while req1=1.
  - FSM returns to IDLE after 4 OWN0 cycles.
  - ack1 follows immediately.
- **Reset mid-read:** assert rst low in the cycle after a read ack.
  - rvalid is 0 on the following cycle.
  - state_out=0.
  - The next tie goes to requester 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// default widths and the lock-counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_MAX_LOCK   = 16;

  // Counter only ever has to reach MAX_LOCK-1, so $clog2 bits are enough.
  function automatic int lock_cnt_width(input int max_lock);
    return (max_lock < 2) ? 1 : $clog2(max_lock);
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not served last. Grant is one-hot or zero.
module mem_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between two requesters with
// round-robin arbitration, timed-out locking and per-requester read return.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_LOCK   = DEFAULT_MAX_LOCK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  lock0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  lock1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [1:0]            state_out
);

  localparam int              CW       = lock_cnt_width(MAX_LOCK);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_LOCK - 1);

  arb_state_e    state, state_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          last, last_nxt;
  logic [1:0]    grant;
  logic [1:0]    ack;

  mem_arb_rr_pick u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .grant (grant)
  );

  // Acks are suppressed while reset is asserted so nothing reaches memory.
  always_comb begin
    ack          = 2'b00;
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    if (rst) begin
      case (state)
        IDLE: begin
          ack          = grant;
          lock_cnt_nxt = '0;
          if (grant[0] && lock0)      state_nxt = OWN0;
          else if (grant[1] && lock1) state_nxt = OWN1;
        end
        OWN0: begin
          ack[0]       = req0;
          lock_cnt_nxt = lock_cnt + CW'(1);
          if (!lock0 || (lock_cnt == CNT_LAST)) state_nxt = IDLE;
        end
        OWN1: begin
          ack[1]       = req1;
          lock_cnt_nxt = lock_cnt + CW'(1);
          if (!lock1 || (lock_cnt == CNT_LAST)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    last_nxt = last;
    if (ack[0])      last_nxt = 1'b0;
    else if (ack[1]) last_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      last     <= 1'b1;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      last     <= last_nxt;
      rvalid0  <= ack[0] & ~we0;
      rvalid1  <= ack[1] & ~we1;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (ack[0]) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end else if (ack[1]) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end
  end

  // Memory data lands one cycle after the address, i.e. during the rvalid cycle.
  assign rdata0    = rvalid0 ? mem_dout : '0;
  assign rdata1    = rvalid1 ? mem_dout : '0;
  assign ack0      = ack[0];
  assign ack1      = ack[1];
  assign state_out = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 memory, a shadow
// copy of its contents and per-requester read-data scoreboards.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 0, lock0 = 0, we0 = 0, req1 = 0, lock1 = 0, we1 = 0;
  logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic       ack0, ack1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;
  logic [1:0] state_out;

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];
  logic [7:0] q0[$], q1[$];
  logic       pend0 = 0, pend1 = 0;
  int         tests = 0, fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .state_out(state_out)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic l, input logic w, input logic [7:0] a, input logic [7:0] d);
    req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic l, input logic w, input logic [7:0] a, input logic [7:0] d);
    req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d;
  endtask

  // One cycle: check acks, memory port and state mid-cycle, record expectations.
  task automatic step(input string tag, input logic e0, input logic e1, input logic [1:0] es);
    @(negedge clk);
    check({tag, "_ack0"}, ack0, e0);
    check({tag, "_ack1"}, ack1, e1);
    check({tag, "_state"}, state_out, es);
    if (e0) begin
      check({tag, "_mem_we"}, mem_we, we0);
      check({tag, "_mem_addr"}, mem_addr, addr0);
      if (we0) check({tag, "_mem_din"}, mem_din, wdata0);
    end else if (e1) begin
      check({tag, "_mem_we"}, mem_we, we1);
      check({tag, "_mem_addr"}, mem_addr, addr1);
      if (we1) check({tag, "_mem_din"}, mem_din, wdata1);
    end else begin
      check({tag, "_mem_idle"}, {mem_we, mem_addr, mem_din}, 17'd0);
    end
    if (e0 && !we0) begin q0.push_back(shadow[addr0]); pend0 = 1'b1; end
    if (e0 && we0)  shadow[addr0] = wdata0;
    if (e1 && !we1) begin q1.push_back(shadow[addr1]); pend1 = 1'b1; end
    if (e1 && we1)  shadow[addr1] = wdata1;
    @(posedge clk); #1;
  endtask

  // Read-return scoreboard, sampled just after each edge.
  always begin
    @(posedge clk); #2;
    check("rvalid0", rvalid0, pend0);
    check("rvalid1", rvalid1, pend1);
    if (pend0 && q0.size() > 0) check("rdata0", rdata0, q0.pop_front());
    else                        check("rdata0_idle", rdata0, 8'h00);
    if (pend1 && q1.size() > 0) check("rdata1", rdata1, q1.pop_front());
    else                        check("rdata1_idle", rdata1, 8'h00);
    pend0 = 1'b0;
    pend1 = 1'b0;
  end

  initial begin
    @(posedge clk); #1;
    step("reset", 0, 0, IDLE);
    rst = 1'b1;
    step("post_reset", 0, 0, IDLE);

    // Single write then read through requester 0
    drive0(1, 0, 1, 8'h10, 8'hA5);  step("wr10", 1, 0, IDLE);
    drive0(1, 0, 0, 8'h10, 8'h00);  step("rd10", 1, 0, IDLE);
    drive0(0, 0, 0, 8'h00, 8'h00);  step("idle1", 0, 0, IDLE);

    // Contention: alternation starting with requester 0
    drive1(1, 0, 1, 8'h11, 8'h3C);  step("wr11", 0, 1, IDLE);
    drive0(1, 0, 0, 8'h10, 8'h00);
    drive1(1, 0, 0, 8'h11, 8'h00);
    for (int i = 0; i < 6; i++) step("rr", (i % 2) == 0, (i % 2) == 1, IDLE);
    drive0(0, 0, 0, 8'h00, 8'h00);
    drive1(0, 0, 0, 8'h00, 8'h00);  step("idle2", 0, 0, IDLE);

    // Locked read-modify-write by requester 1 with requester 0 waiting
    drive0(1, 0, 1, 8'h20, 8'h40);  step("wr20", 1, 0, IDLE);
    drive0(1, 0, 1, 8'h30, 8'h77);
    drive1(1, 1, 0, 8'h20, 8'h00);  step("rmw_rd", 0, 1, IDLE);
    drive1(1, 0, 1, 8'h20, 8'h41);  step("rmw_wr", 0, 1, OWN1);
    drive1(0, 0, 0, 8'h00, 8'h00);  step("rmw_rel", 1, 0, IDLE);
    drive0(1, 0, 0, 8'h20, 8'h00);  step("rd20", 1, 0, IDLE);
    drive0(1, 0, 0, 8'h30, 8'h00);  step("rd30", 1, 0, IDLE);
    drive0(0, 0, 0, 8'h00, 8'h00);

    // Lock timeout with MAX_LOCK=4
    drive1(1, 0, 0, 8'h11, 8'h00);  step("rd11", 0, 1, IDLE);
    drive0(1, 1, 0, 8'h10, 8'h00);  step("to_enter", 1, 0, IDLE);
    for (int i = 0; i < 4; i++) step("to_own", 1, 0, OWN0);
    step("to_exit", 0, 1, IDLE);
    drive0(0, 0, 0, 8'h00, 8'h00);
    drive1(0, 0, 0, 8'h00, 8'h00);  step("idle3", 0, 0, IDLE);

    // Reset in the cycle after a read ack
    drive0(1, 0, 0, 8'h10, 8'h00);  step("rd_pre_rst", 1, 0, IDLE);
    drive1(1, 0, 0, 8'h11, 8'h00);
    rst = 1'b0;                     step("in_rst", 0, 0, IDLE);
    rst = 1'b1;                     step("tie_after_rst", 1, 0, IDLE);
    drive0(0, 0, 0, 8'h00, 8'h00);
    drive1(0, 0, 0, 8'h00, 8'h00);  step("idle4", 0, 0, IDLE);

    @(posedge clk); #3;
    check("sb0_empty", q0.size(), 0);
    check("sb1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
